// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline, UART loader and debug reader share
// one 128-bit port with bounded starvation and a LOAD mode for UART fills.
//
// state | meaning
// RUN   | normal operation, pipeline has priority, starvation bound active
// LOAD  | pipeline held off, UART loader then debug reader served
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              uart_mode_i,
  input  logic              pipe_req_i,
  input  logic              pipe_we_i,
  input  logic [ADDR_W-1:0] pipe_addr_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic              pipe_stall_o,
  output logic              pipe_rvalid_o,
  output logic [DATA_W-1:0] pipe_rdata_o,
  input  logic              uart_req_i,
  input  logic [ADDR_W-1:0] uart_addr_i,
  input  logic [DATA_W-1:0] uart_wdata_i,
  output logic              uart_ack_o,
  input  logic              user_req_i,
  input  logic [ADDR_W-1:0] user_addr_i,
  output logic              user_rvalid_o,
  output logic [DATA_W-1:0] user_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic {ST_RUN, ST_LOAD} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_USER} owner_e;

  localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [7:0]  uart_cnt_q, uart_cnt_d;
  logic [7:0]  user_cnt_q, user_cnt_d;
  logic [DATA_W-1:0] pipe_hold_q, user_hold_q;

  logic gnt_pipe, gnt_uart, gnt_user;
  logic force_uart, force_user;

  assign force_uart = uart_req_i && (uart_cnt_q == CNT_MAX);
  assign force_user = user_req_i && (user_cnt_q == CNT_MAX);

  always_comb begin
    gnt_pipe = 1'b0;
    gnt_uart = 1'b0;
    gnt_user = 1'b0;
    if (state_q == ST_LOAD) begin
      if (uart_req_i)      gnt_uart = 1'b1;
      else if (user_req_i) gnt_user = 1'b1;
    end else begin
      if (force_uart)      gnt_uart = 1'b1;
      else if (force_user) gnt_user = 1'b1;
      else if (pipe_req_i) gnt_pipe = 1'b1;
      else if (uart_req_i) gnt_uart = 1'b1;
      else if (user_req_i) gnt_user = 1'b1;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (gnt_pipe) begin
      mem_addr_o  = pipe_addr_i;
      mem_we_o    = pipe_we_i;
      mem_wdata_o = pipe_wdata_i;
    end else if (gnt_uart) begin
      mem_addr_o  = uart_addr_i;
      mem_we_o    = 1'b1;
      mem_wdata_o = uart_wdata_i;
    end else if (gnt_user) begin
      mem_addr_o  = user_addr_i;
    end
  end

  assign pipe_stall_o = (state_q == ST_LOAD) ? 1'b1 : (pipe_req_i && !gnt_pipe);
  assign uart_ack_o   = gnt_uart;

  // Memory read data arrives the cycle after issue; pass it straight to the
  // owner that cycle and keep a copy so rdata holds once the pulse ends.
  assign pipe_rvalid_o = (owner_q == OWN_PIPE);
  assign user_rvalid_o = (owner_q == OWN_USER);
  assign pipe_rdata_o  = pipe_rvalid_o ? mem_rdata_i : pipe_hold_q;
  assign user_rdata_o  = user_rvalid_o ? mem_rdata_i : user_hold_q;

  always_comb begin
    uart_cnt_d = '0;
    user_cnt_d = '0;
    if (state_q == ST_RUN) begin
      if (uart_req_i && !gnt_uart)
        uart_cnt_d = (uart_cnt_q == CNT_MAX) ? CNT_MAX : uart_cnt_q + 8'd1;
      if (user_req_i && !gnt_user)
        user_cnt_d = (user_cnt_q == CNT_MAX) ? CNT_MAX : user_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (uart_mode_i) state_d = ST_LOAD;
      ST_LOAD: if (!uart_mode_i && !uart_req_i) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_pipe && !pipe_we_i) owner_d = OWN_PIPE;
    else if (gnt_user)          owner_d = OWN_USER;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      owner_q     <= OWN_NONE;
      uart_cnt_q  <= '0;
      user_cnt_q  <= '0;
      pipe_hold_q <= '0;
      user_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      uart_cnt_q <= uart_cnt_d;
      user_cnt_q <= user_cnt_d;
      if (owner_q == OWN_PIPE) pipe_hold_q <= mem_rdata_i;
      if (owner_q == OWN_USER) user_hold_q <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal checks plus a
// cycle-by-cycle priority/return model compared on every falling edge.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 128;
  localparam int SM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr;
  logic uart_mode, pipe_req, pipe_we, uart_req, user_req;
  logic [AW-1:0] pipe_addr, uart_addr, user_addr, mem_addr;
  logic [DW-1:0] pipe_wdata, uart_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] pipe_rdata, user_rdata;
  logic pipe_stall, pipe_rvalid, uart_ack, user_rvalid, mem_we;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_mode_i(uart_mode),
    .pipe_req_i(pipe_req), .pipe_we_i(pipe_we), .pipe_addr_i(pipe_addr),
    .pipe_wdata_i(pipe_wdata), .pipe_stall_o(pipe_stall),
    .pipe_rvalid_o(pipe_rvalid), .pipe_rdata_o(pipe_rdata),
    .uart_req_i(uart_req), .uart_addr_i(uart_addr), .uart_wdata_i(uart_wdata),
    .uart_ack_o(uart_ack), .user_req_i(user_req), .user_addr_i(user_addr),
    .user_rvalid_o(user_rvalid), .user_rdata_o(user_rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Synchronous single-port memory attached to the arbiter
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who wins this cycle, how long each waiter has lost,
  // which read comes back next cycle and what the memory holds.
  int m_load, m_ucnt, m_dcnt, m_ret;
  logic [DW-1:0] m_ret_data, m_phold, m_dhold;
  logic [DW-1:0] exp_mem [0:255];

  always @(negedge clk) begin
    int g;  // 0 none, 1 pipe, 2 uart, 3 user
    logic [AW-1:0] e_addr;
    logic e_we;
    logic [DW-1:0] e_wd;
    if (clr) for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    if (!rst_n) begin
      m_load = 0; m_ucnt = 0; m_dcnt = 0; m_ret = 0;
      m_ret_data = '0; m_phold = '0; m_dhold = '0;
    end
    g = 0;
    if (m_load != 0) begin
      if (uart_req) g = 2;
      else if (user_req) g = 3;
    end else begin
      if (uart_req && m_ucnt == SM) g = 2;
      else if (user_req && m_dcnt == SM) g = 3;
      else if (pipe_req) g = 1;
      else if (uart_req) g = 2;
      else if (user_req) g = 3;
    end
    e_addr = '0; e_we = 1'b0; e_wd = '0;
    if (g == 1) begin e_addr = pipe_addr; e_we = pipe_we; e_wd = pipe_wdata; end
    if (g == 2) begin e_addr = uart_addr; e_we = 1'b1; e_wd = uart_wdata; end
    if (g == 3) e_addr = user_addr;

    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", mem_we, e_we);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("pipe_stall", pipe_stall, (m_load != 0) || (pipe_req && g != 1));
    chk("uart_ack", uart_ack, g == 2);
    chk("pipe_rvalid", pipe_rvalid, m_ret == 1);
    chk("user_rvalid", user_rvalid, m_ret == 2);
    chk("pipe_rdata", pipe_rdata, (m_ret == 1) ? m_ret_data : m_phold);
    chk("user_rdata", user_rdata, (m_ret == 2) ? m_ret_data : m_dhold);

    if (rst_n) begin
      if (m_ret == 1) m_phold = m_ret_data;
      if (m_ret == 2) m_dhold = m_ret_data;
      m_ret = 0;
      if (g == 1 && !pipe_we) begin m_ret = 1; m_ret_data = exp_mem[pipe_addr[7:0]]; end
      if (g == 3) begin m_ret = 2; m_ret_data = exp_mem[user_addr[7:0]]; end
      if (e_we) exp_mem[e_addr[7:0]] = e_wd;
      if (m_load != 0) begin
        m_ucnt = 0; m_dcnt = 0;
        if (!uart_mode && !uart_req) m_load = 0;
      end else begin
        m_ucnt = (uart_req && g != 2) ? ((m_ucnt < SM) ? m_ucnt + 1 : SM) : 0;
        m_dcnt = (user_req && g != 3) ? ((m_dcnt < SM) ? m_dcnt + 1 : SM) : 0;
        if (uart_mode) m_load = 1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    uart_mode = 0; pipe_req = 0; pipe_we = 0; uart_req = 0; user_req = 0;
    pipe_addr = '0; uart_addr = '0; user_addr = '0;
    pipe_wdata = '0; uart_wdata = '0;
  endtask

  initial begin
    all_idle();
    clr = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_pipe_rvalid", pipe_rvalid, 1'b0);
    chk("reset_user_rdata", user_rdata, '0);
    chk("reset_mem_addr", mem_addr, '0);
    #1;
    rst_n = 1'b1;
    clr = 1'b0;
    next_cycle();

    // Store 50 to 0x0001, then load it back
    pipe_req = 1; pipe_we = 1; pipe_addr = 16'h0001; pipe_wdata = 128'd50;
    @(negedge clk);
    chk("st_stall", pipe_stall, 1'b0);
    chk("st_we", mem_we, 1'b1);
    next_cycle();
    pipe_we = 0; pipe_wdata = '0;
    @(negedge clk);
    chk("ld_stall", pipe_stall, 1'b0);
    next_cycle();
    all_idle();
    @(negedge clk);
    chk("ld_rvalid", pipe_rvalid, 1'b1);
    chk("ld_rdata", pipe_rdata, 128'd50);
    next_cycle();
    @(negedge clk);
    chk("ld_pulse_end", pipe_rvalid, 1'b0);
    chk("ld_rdata_hold", pipe_rdata, 128'd50);
    next_cycle();

    // Pipeline vs debug reader: user forced on cycle 9
    pipe_req = 1; pipe_addr = 16'h0002; user_req = 1; user_addr = 16'h0001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("cont_stall", pipe_stall, c == 9);
      chk("cont_user_rvalid", user_rvalid, c == 10);
      if (c == 10) chk("cont_user_rdata", user_rdata, 128'd50);
      next_cycle();
    end
    all_idle();
    next_cycle();

    // All three contending: UART forced, then user, never together
    pipe_req = 1; pipe_addr = 16'h0002;
    uart_req = 1; uart_addr = 16'h0004; uart_wdata = 128'd33;
    user_req = 1; user_addr = 16'h0001;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("dual_ack", uart_ack, c == 9);
      chk("dual_stall", pipe_stall, (c == 9) || (c == 10));
      chk("dual_user_rvalid", user_rvalid, c == 11);
      next_cycle();
    end
    all_idle();
    next_cycle();

    // LOAD mode; the entry cycle still arbitrates in RUN
    uart_mode = 1; pipe_req = 1; pipe_addr = 16'h0004;
    @(negedge clk);
    chk("mode_entry_stall", pipe_stall, 1'b0);
    next_cycle();
    uart_req = 1; uart_addr = 16'h0005; uart_wdata = 128'd86;
    @(negedge clk);
    chk("load_stall", pipe_stall, 1'b1);
    chk("load_ack", uart_ack, 1'b1);
    chk("load_late_rdata", pipe_rdata, 128'd33);
    next_cycle();
    uart_req = 0; uart_mode = 0; pipe_addr = 16'h0005;
    @(negedge clk);
    chk("load_exit_stall", pipe_stall, 1'b1);
    chk("load_exit_ack", uart_ack, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("run_again_stall", pipe_stall, 1'b0);
    next_cycle();
    all_idle();
    @(negedge clk);
    chk("run_ld_rvalid", pipe_rvalid, 1'b1);
    chk("run_ld_rdata", pipe_rdata, 128'd86);
    next_cycle();

    // Reset between a debug read grant and its return
    user_req = 1; user_addr = 16'h0005;
    next_cycle();
    user_req = 0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_user_rvalid", user_rvalid, 1'b0);
    chk("rst_user_rdata", user_rdata, '0);
    chk("rst_pipe_rdata", pipe_rdata, '0);
    #1;
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post_rst_user_rvalid", user_rvalid, 1'b0);
    next_cycle();
    pipe_req = 1; pipe_addr = 16'h0001;
    @(negedge clk);
    chk("post_rst_run", pipe_stall, 1'b0);
    next_cycle();
    all_idle();

    // Idle
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_we", mem_we, 1'b0);
      chk("idle_addr", mem_addr, '0);
      chk("idle_user_rvalid", user_rvalid, 1'b0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 128-bit data memory of the memory stage between three requesters:
- pipeline load/store (highest normal priority);
- UART program/data loader (write-only);
- user debug read port.
It issues at most one access per cycle, returns synchronous read data to the owner one cycle later, stalls the pipeline when it loses arbitration, and bounds starvation of the lower-priority requesters. A LOAD mode holds the pipeline off while the UART fills memory.

Parameters:
ADDR_W, 16, memory word address width
DATA_W, 128, data width
STARVE_MAX, 8, consecutive lost cycles before a waiting UART/user request is force-granted (range 1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
uart_mode  in  1  1 = enter/stay in LOAD mode
pipe_req  in  1  pipeline access request
pipe_we  in  1  1 = store, 0 = load
pipe_addr  in  ADDR_W  pipeline address
pipe_wdata  in  DATA_W  store data
pipe_stall  out  1  pipeline request not accepted this cycle
pipe_rvalid  out  1  load data valid
pipe_rdata  out  DATA_W  load data
uart_req  in  1  UART write request
uart_addr  in  ADDR_W  UART write address
uart_wdata  in  DATA_W  UART write data
uart_ack  out  1  UART write accepted this cycle
user_req  in  1  debug read request
user_addr  in  ADDR_W  debug read address
user_rvalid  out  1  debug read data valid
user_rdata  out  DATA_W  debug read data
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read is issued

Behaviour:
- Reset (rst=0, async): state=RUN; both starvation counters=0; read-owner register=NONE; pipe_rvalid=user_rvalid=0; pipe_rdata=user_rdata=0. Combinational outputs follow the no-grant values below.
- Grant is combinational from the requests, the current state and the counters. Exactly 0 or 1 grant per cycle.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - On a grant: mem_* carry the granted requester's fields. mem_we=pipe_we for pipe, 1 for uart, 0 for user.
- FSM states:
  - RUN: priority is forced UART (uart_cnt==STARVE_MAX) > forced user (user_cnt==STARVE_MAX) > pipe > uart > user.
  - LOAD: pipeline is never granted; priority is uart > user. Starvation counters are held at 0.
  - RUN->LOAD at the clock edge where uart_mode=1.
  - LOAD->RUN at the edge where uart_mode=0 and uart_req=0. A pending UART write finishes in LOAD first.
- pipe_stall = pipe_req & ~pipe_granted in RUN. pipe_stall = 1 unconditionally in LOAD.
- uart_ack = 1 in the cycle the UART write is granted; the write commits at that edge. The UART holds its request fields until ack.
- Read return, latency 1:
  - A granted pipe load or user read records its owner at the edge.
  - The next cycle, the owner's rvalid=1 and its rdata is a registered copy of mem_rdata.
  - rvalid is a one-cycle pulse. rdata holds its last value afterwards.
  - Back-to-back reads give back-to-back pulses.
  - A store does not create a return.
- Starvation counters (uart_cnt, user_cnt):
  - In RUN, each increments by 1, saturating at STARVE_MAX, when its request is high and not granted.
  - A counter clears to 0 when its requester is granted or its request is low.
  - The forced grant lasts one cycle, then the counter restarts from 0.
  - If both counters are saturated, UART wins; user stays saturated and wins the next cycle.
- A pipeline read and write to the same address in consecutive cycles needs no forwarding; memory ordering is grant order.
- Reset asserted mid-read discards the outstanding return: no rvalid after reset is released.
- uart_mode toggling in the same cycle as a pending pipe request: the mode takes effect at the next edge. The current cycle arbitrates under the current state.

Test Plan:
- Pipe store then load: in RUN, store addr 0x0001 data 50, next cycle load 0x0001 -> pipe_stall=0 both cycles; pipe_rvalid pulses one cycle after the load; pipe_rdata=50.
- Contention: pipe_req and user_req held high, STARVE_MAX=8 -> pipe granted for cycles 1..8, user forced on cycle 9 (pipe_stall=1 only that cycle), user_rvalid on cycle 10.
- Dual starvation: pipe, uart and user held high -> uart forced when saturated, user forced the following cycle; uart_ack and user grant never occur in the same cycle.
- LOAD mode: uart_mode=1, UART writes 0x0005=86 while pipe_req=1 -> pipe_stall=1 throughout, uart_ack pulses; uart_mode=0 -> RUN, and a pipe load of 0x0005 returns 86.
- Reset mid-read: user read issued, rst low before the return edge -> user_rvalid stays 0, all outputs at reset values, state RUN.
- Idle: all requests low -> mem_we=0, mem_addr=0, no rvalid, both counters stay 0.
